gpio_write_master: RTL and testbench

Fabric-side bus master that generates the shared 32-bit configuration GPIO bus consumed by the per-address config registers (addr in bits 15:0, data in bits 23:16, write strobe `w_clk` in bit 24). It accepts one multi-byte register write per command and serialises it into byte writes, most significant byte first, with fixed setup, strobe and gap timing. Sequencers inside the fabric use it to load configuration registers without PS involvement.

---
 rtl/gpio_write_master.sv | 181 ++++++++++++++++++
 tb/tb_gpio_write_master.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_write_master.sv
`default_nettype none
// ============================================================================
//  Module   : gpio_write_master
//  Purpose  : Fabric-side master for the shared 32-bit configuration GPIO bus.
//             Takes one multi-byte register write per command and serialises
//             it into byte writes, most significant byte first. Every byte
//             gets SETUP_CYCLES of stable addr/data, then HOLD_CYCLES with
//             w_clk high, then GAP_CYCLES with w_clk low and addr/data held.
//  Ports    : clk, rst         - clock, synchronous active-high reset
//             cmd_valid/ready  - command handshake
//             cmd_addr         - 16-bit target bus address
//             cmd_data         - payload, LSB-aligned, MAX_BYTES*8 bits
//             cmd_len          - byte count, legal range 1..MAX_BYTES
//             gpio_out         - [15:0] addr, [23:16] data, [24] w_clk
//             busy             - high from acceptance until completion
//             done, err        - completion pulse; err marks an illegal length
//  Revision : 1.0 - initial release
// ============================================================================
module gpio_write_master #(
    parameter int MAX_BYTES    = 8,
    parameter int SETUP_CYCLES = 1,
    parameter int HOLD_CYCLES  = 2,
    parameter int GAP_CYCLES   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [15:0]            cmd_addr,
    input  logic [MAX_BYTES*8-1:0] cmd_data,
    input  logic [3:0]             cmd_len,
    output logic [31:0]            gpio_out,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int          C_DW         = MAX_BYTES * 8;
    localparam logic [15:0] C_SETUP_LAST = 16'(SETUP_CYCLES - 1);
    localparam logic [15:0] C_HOLD_LAST  = 16'(HOLD_CYCLES - 1);
    localparam logic [15:0] C_GAP_LAST   = 16'(GAP_CYCLES - 1);
    localparam int          C_WCLK_BIT   = 24;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

    state_t          r_state, w_state_nx;
    logic [15:0]     r_cnt,   w_cnt_nx;
    logic [3:0]      r_idx,   w_idx_nx;
    logic [C_DW-1:0] r_data,  w_data_nx;
    logic [31:0]     r_gpio,  w_gpio_nx;
    logic            r_busy,  w_busy_nx;
    logic            r_done,  w_done_nx;
    logic            r_err,   w_err_nx;
    logic            r_ready, w_ready_nx;

    logic            w_len_ok;
    logic [3:0]      w_first_idx;

    // Byte i of a payload word.
    function automatic logic [7:0] pick_byte(input logic [C_DW-1:0] d,
                                             input logic [3:0]      i);
        pick_byte = 8'(d >> {i, 3'b000});
    endfunction

    assign w_len_ok    = (cmd_len != 4'd0) && (int'(cmd_len) <= MAX_BYTES);
    assign w_first_idx = cmd_len - 4'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_data  <= '0;
            r_gpio  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_idx   <= w_idx_nx;
            r_data  <= w_data_nx;
            r_gpio  <= w_gpio_nx;
            r_busy  <= w_busy_nx;
            r_done  <= w_done_nx;
            r_err   <= w_err_nx;
            r_ready <= w_ready_nx;
        end
    end

    // Next-state and next-output logic. Outputs are computed one edge ahead so
    // that every port comes straight from a flop.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_idx_nx   = r_idx;
        w_data_nx  = r_data;
        w_gpio_nx  = r_gpio;
        w_busy_nx  = r_busy;
        w_done_nx  = 1'b0;
        w_err_nx   = 1'b0;
        w_ready_nx = r_ready;

        case (r_state)
            ST_IDLE: begin
                if (cmd_valid && r_ready) begin
                    if (w_len_ok) begin
                        w_state_nx = ST_SETUP;
                        w_cnt_nx   = '0;
                        w_idx_nx   = w_first_idx;
                        w_data_nx  = cmd_data;
                        w_gpio_nx  = {8'h00, pick_byte(cmd_data, w_first_idx), cmd_addr};
                        w_busy_nx  = 1'b1;
                        w_ready_nx = 1'b0;
                    end else begin
                        // Illegal length: report and stay idle, bus untouched.
                        w_done_nx = 1'b1;
                        w_err_nx  = 1'b1;
                    end
                end
            end

            ST_SETUP: begin
                if (r_cnt == C_SETUP_LAST) begin
                    w_state_nx            = ST_STROBE;
                    w_cnt_nx              = '0;
                    w_gpio_nx[C_WCLK_BIT] = 1'b1;
                end else begin
                    w_cnt_nx = r_cnt + 16'd1;
                end
            end

            ST_STROBE: begin
                if (r_cnt == C_HOLD_LAST) begin
                    w_state_nx            = ST_GAP;
                    w_cnt_nx              = '0;
                    w_gpio_nx[C_WCLK_BIT] = 1'b0;
                end else begin
                    w_cnt_nx = r_cnt + 16'd1;
                end
            end

            ST_GAP: begin
                if (r_cnt == C_GAP_LAST) begin
                    w_cnt_nx = '0;
                    if (r_idx != 4'd0) begin
                        // Data changes only on entry to SETUP.
                        w_state_nx       = ST_SETUP;
                        w_idx_nx         = r_idx - 4'd1;
                        w_gpio_nx[23:16] = pick_byte(r_data, r_idx - 4'd1);
                    end else begin
                        w_state_nx = ST_IDLE;
                        w_done_nx  = 1'b1;
                        w_busy_nx  = 1'b0;
                        w_ready_nx = 1'b1;
                    end
                end else begin
                    w_cnt_nx = r_cnt + 16'd1;
                end
            end

            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    assign gpio_out  = r_gpio;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign cmd_ready = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_gpio_write_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gpio_write_master
//  Purpose  : Self-checking bench for gpio_write_master. A default-parameter
//             instance and an S=2/H=1/G=3 instance are compared cycle by
//             cycle against a timing model computed from byte position and
//             phase arithmetic, and strobed bytes are collected per instance.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gpio_write_master;

    localparam int S1 = 1, H1 = 2, G1 = 2;
    localparam int S2 = 2, H2 = 1, G2 = 3;

    logic        clk = 1'b0;
    logic        rst;
    // instance 1 (defaults)
    logic        cmd_valid, cmd_ready, busy, done, err;
    logic [15:0] cmd_addr;
    logic [63:0] cmd_data;
    logic [3:0]  cmd_len;
    logic [31:0] gpio_out;
    // instance 2 (non-default timing)
    logic        v2, rdy2, b2, dn2, e2;
    logic [15:0] a2;
    logic [63:0] d2;
    logic [3:0]  l2;
    logic [31:0] g2;

    int total = 0;
    int bad   = 0;
    logic [31:0] last_g1;

    logic [23:0] q1[$];
    logic [23:0] q2[$];
    logic        prev1 = 1'b0, prev2 = 1'b0;

    always #5 clk = ~clk;

    gpio_write_master #(.MAX_BYTES(8), .SETUP_CYCLES(S1), .HOLD_CYCLES(H1), .GAP_CYCLES(G1)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_len(cmd_len),
        .gpio_out(gpio_out), .busy(busy), .done(done), .err(err));

    gpio_write_master #(.MAX_BYTES(8), .SETUP_CYCLES(S2), .HOLD_CYCLES(H2), .GAP_CYCLES(G2)) dut2 (
        .clk(clk), .rst(rst), .cmd_valid(v2), .cmd_ready(rdy2),
        .cmd_addr(a2), .cmd_data(d2), .cmd_len(l2),
        .gpio_out(g2), .busy(b2), .done(dn2), .err(e2));

    // Target-side view: record {data, addr} on every w_clk rising edge.
    always @(posedge clk) begin
        if (gpio_out[24] && !prev1) q1.push_back(gpio_out[23:0]);
        if (g2[24] && !prev2)       q2.push_back(g2[23:0]);
        prev1 <= gpio_out[24];
        prev2 <= g2[24];
    end

    // Expected bus value in cycle c after acceptance (c >= 1).
    function automatic logic [31:0] model_gpio(input logic [15:0] a, input logic [63:0] d,
                                               input int len, input int c,
                                               input int s, input int h, input int g);
        int p, k, r;
        logic [63:0] t;
        p = s + h + g;
        if (c > len * p) begin
            k = len - 1;
            r = p;
        end else begin
            k = (c - 1) / p;
            r = (c - 1) % p;
        end
        t = d >> (8 * (len - 1 - k));
        return {7'b0, (r >= s && r < s + h), t[7:0], a};
    endfunction

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b1; cmd_valid = 1'b1; cmd_addr = 16'h1234; cmd_data = 64'hFF; cmd_len = 4'd1;
        v2 = 1'b0; a2 = '0; d2 = '0; l2 = 4'd1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; cmd_valid = 1'b0;
        total++; if (gpio_out !== 32'h0) begin bad++; $display("FAIL reset_gpio got=%h exp=%h", gpio_out, 32'h0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
        total++; if (g2 !== 32'h0 || rdy2 !== 1'b1) begin bad++; $display("FAIL reset_dut2 got=%h/%b exp=0/1", g2, rdy2); end
        @(negedge clk);
        total++; if (busy !== 1'b0 || gpio_out !== 32'h0) begin bad++; $display("FAIL reset_drop_cmd got busy=%b gpio=%h exp busy=0 gpio=0", busy, gpio_out); end
        last_g1 = 32'h0;
    endtask

    task automatic test_single;
        int n;
        logic [31:0] exp;
        n = 1 * (S1 + H1 + G1) + 1;
        cmd_valid = 1'b1; cmd_addr = 16'h0005; cmd_data = 64'hA7; cmd_len = 4'd1;
        @(posedge clk);
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            if (c == 1) cmd_valid = 1'b0;
            exp = model_gpio(16'h0005, 64'hA7, 1, c, S1, H1, G1);
            total++; if (gpio_out !== exp) begin bad++; $display("FAIL single_gpio c=%0d got=%h exp=%h", c, gpio_out, exp); end
            total++; if (done !== 1'(c == n)) begin bad++; $display("FAIL single_done c=%0d got=%b exp=%b", c, done, c == n); end
            total++; if (busy !== 1'(c < n)) begin bad++; $display("FAIL single_busy c=%0d got=%b exp=%b", c, busy, c < n); end
        end
        last_g1 = 32'h00A70005;
    endtask

    task automatic test_multi;
        int n;
        logic [31:0] exp, cfg;
        n = 4 * (S1 + H1 + G1) + 1;
        q1.delete();
        cmd_valid = 1'b1; cmd_addr = 16'h0012; cmd_data = 64'h11223344; cmd_len = 4'd4;
        @(posedge clk);
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            if (c == 1) cmd_valid = 1'b0;
            exp = model_gpio(16'h0012, 64'h11223344, 4, c, S1, H1, G1);
            total++; if (gpio_out !== exp) begin bad++; $display("FAIL multi_gpio c=%0d got=%h exp=%h", c, gpio_out, exp); end
            total++; if (done !== 1'(c == n)) begin bad++; $display("FAIL multi_done c=%0d got=%b exp=%b", c, done, c == n); end
        end
        total++; if (q1.size() != 4) begin bad++; $display("FAIL multi_strobes got=%0d exp=4", q1.size()); end
        cfg = 32'h0;
        foreach (q1[i]) if (q1[i][15:0] == 16'h0012) cfg = {cfg[23:0], q1[i][23:16]};
        total++; if (cfg !== 32'h11223344) begin bad++; $display("FAIL multi_cfgreg got=%h exp=%h", cfg, 32'h11223344); end
        last_g1 = 32'h00440012;
    endtask

    task automatic test_back_to_back;
        int n;
        logic [31:0] exp;
        logic [63:0] da, db;
        n = 2 * (S1 + H1 + G1) + 1;
        da = {48'h0, 16'($urandom)};
        db = {48'h0, 16'($urandom)};
        cmd_valid = 1'b1; cmd_addr = 16'h0100; cmd_data = da; cmd_len = 4'd2;
        @(posedge clk);
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            if (c == 1) begin cmd_addr = 16'h0200; cmd_data = db; end
            exp = model_gpio(16'h0100, da, 2, c, S1, H1, G1);
            total++; if (gpio_out !== exp) begin bad++; $display("FAIL b2b_first_gpio c=%0d got=%h exp=%h", c, gpio_out, exp); end
            total++; if (cmd_ready !== 1'(c == n)) begin bad++; $display("FAIL b2b_ready c=%0d got=%b exp=%b", c, cmd_ready, c == n); end
        end
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            if (c == 1) cmd_valid = 1'b0;
            exp = model_gpio(16'h0200, db, 2, c, S1, H1, G1);
            total++; if (gpio_out !== exp) begin bad++; $display("FAIL b2b_second_gpio c=%0d got=%h exp=%h", c, gpio_out, exp); end
            total++; if (done !== 1'(c == n)) begin bad++; $display("FAIL b2b_second_done c=%0d got=%b exp=%b", c, done, c == n); end
        end
        last_g1 = model_gpio(16'h0200, db, 2, n, S1, H1, G1);
    endtask

    task automatic test_illegal;
        q1.delete();
        cmd_valid = 1'b1; cmd_addr = 16'hBEEF; cmd_data = 64'h55; cmd_len = 4'd0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 0) cmd_len = 4'd9; else cmd_valid = 1'b0;
            total++; if (done !== 1'b1 || err !== 1'b1) begin bad++; $display("FAIL illegal_pulse k=%0d got done=%b err=%b exp 1/1", k, done, err); end
            total++; if (gpio_out !== last_g1) begin bad++; $display("FAIL illegal_gpio k=%0d got=%h exp=%h", k, gpio_out, last_g1); end
            total++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL illegal_ready k=%0d got ready=%b busy=%b exp 1/0", k, cmd_ready, busy); end
        end
        @(negedge clk);
        total++; if (done !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL illegal_clear got done=%b err=%b exp 0/0", done, err); end
        total++; if (q1.size() != 0) begin bad++; $display("FAIL illegal_wclk got=%0d strobes exp=0", q1.size()); end
    endtask

    task automatic test_random;
        int n, len, gap;
        logic [15:0] a;
        logic [63:0] d, t;
        logic [31:0] exp;
        for (int i = 0; i < 6; i++) begin
            len = $urandom_range(1, 8);
            a = 16'($urandom);
            d = {$urandom, $urandom};
            n = len * (S1 + H1 + G1) + 1;
            q1.delete();
            cmd_valid = 1'b1; cmd_addr = a; cmd_data = d; cmd_len = 4'(len);
            @(posedge clk);
            for (int c = 1; c <= n; c++) begin
                @(negedge clk);
                if (c == 1) begin cmd_valid = 1'b0; cmd_data = {$urandom, $urandom}; end
                exp = model_gpio(a, d, len, c, S1, H1, G1);
                total++; if (gpio_out !== exp) begin bad++; $display("FAIL rand_gpio i=%0d c=%0d got=%h exp=%h", i, c, gpio_out, exp); end
                total++; if (done !== 1'(c == n) || busy !== 1'(c < n)) begin bad++; $display("FAIL rand_ctrl i=%0d c=%0d got done=%b busy=%b", i, c, done, busy); end
            end
            total++; if (q1.size() != len) begin bad++; $display("FAIL rand_count i=%0d got=%0d exp=%0d", i, q1.size(), len); end
            for (int k = 0; k < len && k < q1.size(); k++) begin
                t = d >> (8 * (len - 1 - k));
                total++; if (q1[k] !== {t[7:0], a}) begin bad++; $display("FAIL rand_byte i=%0d k=%0d got=%h exp=%h", i, k, q1[k], {t[7:0], a}); end
            end
            last_g1 = model_gpio(a, d, len, n, S1, H1, G1);
            gap = $urandom_range(0, 2);
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic test_reset_mid;
        logic [63:0] d;
        logic [31:0] exp;
        d = {$urandom, $urandom};
        cmd_valid = 1'b1; cmd_addr = 16'h0033; cmd_data = d; cmd_len = 4'd8;
        @(posedge clk);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 1) cmd_valid = 1'b0;
            exp = model_gpio(16'h0033, d, 8, c, S1, H1, G1);
            total++; if (gpio_out !== exp) begin bad++; $display("FAIL rstmid_gpio c=%0d got=%h exp=%h", c, gpio_out, exp); end
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        total++; if (gpio_out !== 32'h0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL rstmid_state got gpio=%h busy=%b ready=%b exp 0/0/1", gpio_out, busy, cmd_ready); end
        cmd_valid = 1'b1; cmd_addr = 16'h0044; cmd_data = 64'h5A; cmd_len = 4'd1;
        @(posedge clk);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) cmd_valid = 1'b0;
            exp = model_gpio(16'h0044, 64'h5A, 1, c, S1, H1, G1);
            total++; if (gpio_out !== exp) begin bad++; $display("FAIL rstmid_new_gpio c=%0d got=%h exp=%h", c, gpio_out, exp); end
            total++; if (done !== 1'(c == 6)) begin bad++; $display("FAIL rstmid_new_done c=%0d got=%b exp=%b", c, done, c == 6); end
        end
    endtask

    task automatic test_params;
        logic [15:0] a;
        logic [63:0] d, t;
        logic [31:0] exp;
        a = 16'($urandom);
        d = {48'h0, 16'($urandom)};
        q2.delete();
        v2 = 1'b1; a2 = a; d2 = d; l2 = 4'd2;
        @(posedge clk);
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            if (c == 1) v2 = 1'b0;
            exp = model_gpio(a, d, 2, c, S2, H2, G2);
            total++; if (g2 !== exp) begin bad++; $display("FAIL params_gpio c=%0d got=%h exp=%h", c, g2, exp); end
            total++; if (g2[24] !== 1'(c == 3 || c == 9)) begin bad++; $display("FAIL params_wclk c=%0d got=%b exp=%b", c, g2[24], c == 3 || c == 9); end
            total++; if (dn2 !== 1'(c == 13)) begin bad++; $display("FAIL params_done c=%0d got=%b exp=%b", c, dn2, c == 13); end
        end
        total++; if (q2.size() != 2) begin bad++; $display("FAIL params_strobes got=%0d exp=2", q2.size()); end
        t = d >> 8;
        total++; if (q2.size() > 0 && q2[0] !== {t[7:0], a}) begin bad++; $display("FAIL params_first_byte got=%h exp=%h", q2[0], {t[7:0], a}); end
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_addr = '0; cmd_data = '0; cmd_len = '0;
        v2 = 1'b0; a2 = '0; d2 = '0; l2 = '0;
        last_g1 = '0;
        test_reset;
        test_single;
        test_multi;
        test_back_to_back;
        test_illegal;
        test_random;
        test_reset_mid;
        test_params;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
